instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the X9 single-cycle core. Holds the program counter and reads the 9-bit instruction memory. Presents the current instruction and its 5-bit opcode to the control decoder. Advances the PC each cycle, or redirects it through a branch-target lookup table when a branch resolves taken. A Start/Done handshake sequences one program run per Start pulse.

## Interface
- PCW, 10, program counter / instruction memory address width
- IW, 9, instruction width
- LUTW, 4, branch LUT index width (instruction bits [LUTW-1:0])
- Clk  input  1  clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  begin program run; sampled only in IDLE or DONE
- StartAddr  input  PCW  first instruction address of the run
- ProgEnd  input  PCW  address of last instruction of the run
- Branch  input  1  from control decoder; current instruction is beq/bne
- Taken  input  1  from ALU/compare; branch condition true this cycle
- PC  output  PCW  current program counter
- Instr  output  IW  instruction at PC
- Opcode  output  5  Instr[8:4], feeds the control decoder
- Valid  output  1  Instr is live and may commit (gates RegWrite/MemWrite downstream)
- Done  output  1  run complete, registered

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - Valid=0, Done=0.
  - Start=1 → RUN, PC←StartAddr.
- RUN:
  - Valid=1.
  - Each cycle: if Branch&Taken, PC←lut[Instr[LUTW-1:0]].
  - Else if PC==ProgEnd → DONE, PC holds.
  - Else PC←PC+1.
- Branch priority: Branch&Taken at PC==ProgEnd redirects and stays in RUN.
- Branch=1 with Taken=0 behaves as a normal instruction (PC+1 or end-of-program check).
- Start asserted during RUN is ignored.
- DONE:
  - Done=1, Valid=0, PC holds last address.
  - Start=1 → RUN, PC←StartAddr, Done cleared the same edge.
- PC arithmetic is modulo 2^PCW: PC+1 from 2^PCW-1 wraps to 0, with no flag.
- Instr and Opcode always reflect memory at the current PC, including in IDLE and DONE. Only Valid qualifies them.
- Branch LUT is a 2^LUTW × PCW table, read combinationally, constant contents per program image.
- Instruction memory is 2^PCW × IW, read combinationally, with contents loaded at elaboration.

## Timing
- Reset (async, any state, including mid-run) forces: state=IDLE, PC=0, Valid=0, Done=0. Takes effect immediately and independent of Clk.
- First rising edge after Reset deasserts is a normal edge.
- Start→first Valid instruction: 1 cycle. Start is sampled at edge n, and Valid=1 with PC=StartAddr after edge n.
- Fetch latency 0: Instr/Opcode change combinationally with PC.
- Branch resolve latency 0: Branch/Taken are sampled at the same edge that retires the branch. No delay slot, no flush.
- Done rises on the edge after the ProgEnd instruction executes. It stays high until the Start edge or Reset.
- StartAddr==ProgEnd: exactly one Valid cycle, then DONE.
- Start held high continuously: run restarts on the edge after each DONE entry. This gives 1 DONE cycle between runs.

## Structure
- Shared package x9_pkg holds:
  - fetch state enum (IDLE, RUN, DONE)
  - PCW/IW/LUTW default constants
  - opcode field position constants (OPC_MSB=8, OPC_LSB=4)
- One sub-module, branch_lut: combinational index→target table, parameterised by LUTW/PCW.
- Instruction memory stays inside instr_fetch as a plain array.

## Test plan
- Reset mid-run: assert Reset at PC=0x005 in RUN → PC=0, Valid=0, Done=0 immediately, before the next edge; state IDLE.
- Straight-line run: StartAddr=0x000, ProgEnd=0x003, no branches → Valid for PCs 0,1,2,3 on 4 consecutive cycles; Done=1 on the 5th cycle; PC holds 0x003.
- Taken branch: lut[2]=0x010, instruction at 0x001 has Instr[3:0]=2, Branch=1, Taken=1 → next PC=0x010. With Taken=0 instead → next PC=0x002.
- Branch at end: ProgEnd=0x004, taken branch at 0x004 to 0x000 → stays in RUN, PC=0x000, Done stays 0.
- Wrap and restart: StartAddr=ProgEnd=0x3FF → one Valid cycle at 0x3FF, then DONE. Start again with StartAddr=0x3FE, ProgEnd=0x000 → PCs 0x3FE, 0x3FF, 0x000, then Done.
- Start ignored in RUN: pulse Start with StartAddr=0x020 while running at PC=0x002 → PC advances to 0x003, not 0x020.

Source files
------------

// File: rtl/x9_pkg.sv
// Shared definitions for the X9 fetch stage: state encoding, default widths
// and the opcode field position inside an instruction word.
package x9_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    localparam int PCW_DEF  = 10;
    localparam int IW_DEF   = 9;
    localparam int LUTW_DEF = 4;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 4;
    localparam int OPCW    = OPC_MSB - OPC_LSB + 1;

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target table; contents are fixed per program image.
module branch_lut #(
    parameter int LUTW = 4,
    parameter int PCW  = 10,
    parameter logic [(2**LUTW)*PCW-1:0] LUT_INIT = '0
) (
    input  logic [LUTW-1:0] idx_i,
    output logic [PCW-1:0]  target_o
);

    assign target_o = LUT_INIT[int'(idx_i)*PCW +: PCW];

endmodule

// File: rtl/instr_fetch.sv
// X9 fetch stage: program counter, instruction ROM and run sequencing.
//   state   | meaning
//   ST_IDLE | after reset, waiting for start_i
//   ST_RUN  | fetching, valid_o high, PC advances or branches each cycle
//   ST_DONE | last instruction retired, PC holds, waiting for start_i
module instr_fetch
    import x9_pkg::*;
#(
    parameter int PCW  = PCW_DEF,
    parameter int IW   = IW_DEF,
    parameter int LUTW = LUTW_DEF,
    parameter logic [(2**PCW)*IW-1:0]   IMEM_INIT = '0,
    parameter logic [(2**LUTW)*PCW-1:0] LUT_INIT  = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [PCW-1:0]  start_addr_i,
    input  logic [PCW-1:0]  prog_end_i,
    input  logic            branch_i,
    input  logic            taken_i,
    output logic [PCW-1:0]  pc_o,
    output logic [IW-1:0]   instr_o,
    output logic [OPCW-1:0] opcode_o,
    output logic            valid_o,
    output logic            done_o
);

    fetch_state_e   state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic           done_q, done_d;
    logic [PCW-1:0] lut_target;

    logic [IW-1:0] imem [2**PCW];

    for (genvar i = 0; i < 2**PCW; i++) begin : g_imem
        assign imem[i] = IMEM_INIT[i*IW +: IW];
    end

    assign instr_o  = imem[pc_q];
    assign opcode_o = instr_o[OPC_MSB:OPC_LSB];
    assign pc_o     = pc_q;
    assign valid_o  = (state_q == ST_RUN);
    assign done_o   = done_q;

    branch_lut #(
        .LUTW     (LUTW),
        .PCW      (PCW),
        .LUT_INIT (LUT_INIT)
    ) u_branch_lut (
        .idx_i    (instr_o[LUTW-1:0]),
        .target_o (lut_target)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    pc_d    = start_addr_i;
                end
            end
            ST_RUN: begin
                // A taken branch wins even on the last instruction of the run.
                if (branch_i && taken_i) begin
                    pc_d = lut_target;
                end else if (pc_q == prog_end_i) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d = pc_q + PCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase
        done_d = (state_d == ST_DONE);
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed runs push expected PCs, a
// negedge monitor pops one entry per valid cycle and checks PC/Instr/Opcode.
module tb_instr_fetch;
    import x9_pkg::*;

    localparam int PCW  = 10;
    localparam int IW   = 9;
    localparam int LUTW = 4;

    // 16-word pattern repeated through memory; word 1 indexes lut[2],
    // word 4 indexes lut[5]. Listed from word 15 down to word 0.
    localparam logic [16*IW-1:0] BLK = {
        9'h02A, 9'h15F, 9'h0E4, 9'h196, 9'h07B, 9'h1B0, 9'h048, 9'h12D,
        9'h0F9, 9'h16C, 9'h031, 9'h1E5, 9'h08E, 9'h153, 9'h0C2, 9'h1A7
    };
    localparam logic [(2**PCW)*IW-1:0] IMEM = {64{BLK}};
    // lut[2]=0x010, lut[5]=0x000, others 0x100+i. Listed from entry 15 down.
    localparam logic [(2**LUTW)*PCW-1:0] LUT = {
        10'h10F, 10'h10E, 10'h10D, 10'h10C, 10'h10B, 10'h10A, 10'h109, 10'h108,
        10'h107, 10'h106, 10'h000, 10'h104, 10'h103, 10'h010, 10'h101, 10'h100
    };

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [PCW-1:0]  start_addr = '0;
    logic [PCW-1:0]  prog_end = '0;
    logic            branch = 1'b0;
    logic            taken = 1'b0;
    logic [PCW-1:0]  pc_o;
    logic [IW-1:0]   instr_o;
    logic [OPCW-1:0] opcode_o;
    logic            valid_o;
    logic            done_o;

    int checks = 0;
    int failures = 0;
    logic [PCW-1:0] exp_q [$];

    instr_fetch #(
        .PCW       (PCW),
        .IW        (IW),
        .LUTW      (LUTW),
        .IMEM_INIT (IMEM),
        .LUT_INIT  (LUT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .start_addr_i (start_addr),
        .prog_end_i   (prog_end),
        .branch_i     (branch),
        .taken_i      (taken),
        .pc_o         (pc_o),
        .instr_o      (instr_o),
        .opcode_o     (opcode_o),
        .valid_o      (valid_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] img_word(input logic [PCW-1:0] a);
        return BLK[int'(a[3:0])*IW +: IW];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [PCW-1:0] sa, input logic [PCW-1:0] pe);
        start      = 1'b1;
        start_addr = sa;
        prog_end   = pe;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [PCW-1:0] p);
        exp_q.push_back(p);
    endtask

    initial begin : monitor
        logic [PCW-1:0] p;
        logic [IW-1:0]  w;
        logic [OPCW-1:0] opc;
        forever begin
            @(negedge clk);
            if (!rst && valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got valid at pc %0h expected no valid cycle", pc_o);
                end else begin
                    p   = exp_q.pop_front();
                    w   = img_word(p);
                    opc = w[8:4];
                    check("pc", 32'(pc_o), 32'(p));
                    check("instr", 32'(instr_o), 32'(w));
                    check("opcode", 32'(opcode_o), 32'(opc));
                end
            end
        end
    end

    initial begin
        // reset state
        #3;
        check("rst_pc", 32'(pc_o), 32'h0);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        #10 rst = 1'b0;
        tick();
        check("idle_valid", 32'(valid_o), 32'h0);

        // straight-line 0..3
        push(10'h000); push(10'h001); push(10'h002); push(10'h003);
        start_run(10'h000, 10'h003);
        tick(); tick(); tick();
        check("line_done_early", 32'(done_o), 32'h0);
        tick();
        check("line_done", 32'(done_o), 32'h1);
        check("line_pc_hold", 32'(pc_o), 32'h003);
        check("line_valid_off", 32'(valid_o), 32'h0);

        // branch not taken at 0x001
        push(10'h000); push(10'h001); push(10'h002); push(10'h003);
        start_run(10'h000, 10'h003);
        tick();
        branch = 1'b1; taken = 1'b0;
        tick();
        branch = 1'b0;
        tick(); tick();
        check("nt_done", 32'(done_o), 32'h1);

        // branch taken at 0x001 -> lut[2] = 0x010
        push(10'h000); push(10'h001); push(10'h010);
        start_run(10'h000, 10'h010);
        tick();
        branch = 1'b1; taken = 1'b1;
        tick();
        branch = 1'b0; taken = 1'b0;
        tick();
        check("tk_done", 32'(done_o), 32'h1);
        check("tk_pc_hold", 32'(pc_o), 32'h010);

        // taken branch on ProgEnd 0x004 -> lut[5] = 0x000, stays running
        push(10'h002); push(10'h003); push(10'h004);
        push(10'h000); push(10'h001); push(10'h002); push(10'h003); push(10'h004);
        start_run(10'h002, 10'h004);
        tick(); tick();
        branch = 1'b1; taken = 1'b1;
        tick();
        branch = 1'b0; taken = 1'b0;
        check("end_br_done", 32'(done_o), 32'h0);
        check("end_br_valid", 32'(valid_o), 32'h1);
        tick(); tick(); tick(); tick();
        tick();
        check("end_br_final_done", 32'(done_o), 32'h1);

        // start ignored in RUN, then reset mid-run at 0x005
        push(10'h000); push(10'h001); push(10'h002);
        push(10'h003); push(10'h004); push(10'h005);
        start_run(10'h000, 10'h100);
        tick(); tick();
        start = 1'b1; start_addr = 10'h020;
        tick();
        start = 1'b0;
        check("ign_pc", 32'(pc_o), 32'h003);
        tick(); tick();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_pc", 32'(pc_o), 32'h0);
        check("mid_rst_valid", 32'(valid_o), 32'h0);
        check("mid_rst_done", 32'(done_o), 32'h0);
        #1 rst = 1'b0;
        tick();
        check("post_rst_valid", 32'(valid_o), 32'h0);
        check("post_rst_pc", 32'(pc_o), 32'h0);

        // single-instruction run at top of memory, then wrap
        push(10'h3FF);
        start_run(10'h3FF, 10'h3FF);
        tick();
        check("single_done", 32'(done_o), 32'h1);
        check("single_pc", 32'(pc_o), 32'h3FF);
        push(10'h3FE); push(10'h3FF); push(10'h000);
        start_run(10'h3FE, 10'h000);
        check("restart_done_clr", 32'(done_o), 32'h0);
        tick(); tick(); tick();
        check("wrap_done", 32'(done_o), 32'h1);
        check("wrap_pc", 32'(pc_o), 32'h000);

        // Start held high: one DONE cycle between runs
        push(10'h3FF); push(10'h3FF);
        start = 1'b1; start_addr = 10'h3FF; prog_end = 10'h3FF;
        tick();
        check("hold_run1", 32'(valid_o), 32'h1);
        tick();
        check("hold_done1", 32'(done_o), 32'h1);
        tick();
        check("hold_run2_done", 32'(done_o), 32'h0);
        start = 1'b0;
        tick();
        check("hold_done2", 32'(done_o), 32'h1);

        tick(); tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
